ibex_pext_simd_mul: RTL and testbench

IBEX_PEXT_SIMD_MUL -- requirements
Module: ibex_pext_simd_mul

---
 rtl/ibex_pkg_pext.sv | 19 +
 rtl/ibex_pext_mul_lane.sv | 57 +++++
 rtl/ibex_pext_simd_mul.sv | 163 ++++++++++++++++
 tb/tb_ibex_pext_simd_mul.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg_pext.sv
// Shared types and lane-count constants for the packed-SIMD lane multiplier.
// The KHM saturating path is enabled by defining IBEX_PEXT_KHM_EN.
package ibex_pkg_pext;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } pext_mul_state_e;

  localparam int unsigned PEXT_LANES8  = 4;
  localparam int unsigned PEXT_LANES16 = 2;

  // Index of the final lane for the selected lane width.
  function automatic logic [1:0] pext_last_lane(input logic width8);
    return width8 ? 2'(PEXT_LANES8 - 1) : 2'(PEXT_LANES16 - 1);
  endfunction

endpackage

// File: rtl/ibex_pext_mul_lane.sv
// Combinational single-lane multiply: 17x17 signed product, optional Q-format
// shift and saturation (present only when IBEX_PEXT_KHM_EN is defined).
module ibex_pext_mul_lane (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        width8_i,
  input  logic        signed_ops_i,
  input  logic        sat_i,
  output logic [15:0] res_o,
  output logic        ov_o
);

  logic               sext;
  logic signed [16:0] a_ext;
  logic signed [16:0] b_ext;
  logic signed [33:0] prod;
  logic               unused_bits;

  // 8-bit lanes live in the low byte; extend to 17 bits so unsigned 16-bit fits.
  always_comb begin
    a_ext = width8_i ? {{9{sext & a_i[7]}}, a_i[7:0]} : {sext & a_i[15], a_i};
    b_ext = width8_i ? {{9{sext & b_i[7]}}, b_i[7:0]} : {sext & b_i[15], b_i};
    prod  = 34'(a_ext) * 34'(b_ext);
  end

`ifdef IBEX_PEXT_KHM_EN
  logic both_min;

  assign sext        = signed_ops_i | sat_i;
  assign unused_bits = ^prod[33:31];

  // Q-format multiply: min*min is the only product that overflows after the shift.
  always_comb begin
    both_min = width8_i ? (a_i[7:0] == 8'h80 && b_i[7:0] == 8'h80)
                        : (a_i == 16'h8000 && b_i == 16'h8000);
    res_o    = width8_i ? {8'h00, prod[7:0]} : prod[15:0];
    ov_o     = 1'b0;
    if (sat_i) begin
      if (both_min) begin
        res_o = width8_i ? 16'h007F : 16'h7FFF;
        ov_o  = 1'b1;
      end else begin
        res_o = width8_i ? {8'h00, prod[14:7]} : prod[30:15];
      end
    end
  end
`else
  assign sext        = signed_ops_i;
  assign unused_bits = ^{sat_i, prod[33:16]};

  always_comb begin
    res_o = width8_i ? {8'h00, prod[7:0]} : prod[15:0];
    ov_o  = 1'b0;
  end
`endif

endmodule

// File: rtl/ibex_pext_simd_mul.sv
// Sequential packed-SIMD multiplier: one lane per cycle through a shared lane
// multiplier. Define IBEX_PEXT_KHM_EN to enable KHM8/KHM16 saturation and ov_o.
module ibex_pext_simd_mul
  import ibex_pkg_pext::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        kill_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic        width8_i,
  input  logic        signed_ops_i,
  input  logic        sat_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        ov_o
);

  pext_mul_state_e state_q, state_d;
  logic [1:0]      lane_cnt_q, lane_cnt_d;
  logic [31:0]     op_a_q, op_a_d;
  logic [31:0]     op_b_q, op_b_d;
  logic [31:0]     result_q, result_d;
  logic            width8_q, width8_d;
  logic            signed_q, signed_d;
  logic            sat_q, sat_d;
  logic            ov_q, ov_d;

  logic            accept;
  logic            last_lane;
  logic [15:0]     lane_a;
  logic [15:0]     lane_b;
  logic [15:0]     lane_res;
  logic            lane_ov;

  assign accept    = (state_q == IDLE) & valid_i & ~kill_i;
  assign last_lane = (lane_cnt_q == pext_last_lane(width8_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (valid_i)   state_d = BUSY;
        BUSY:    if (last_lane) state_d = DONE;
        DONE:    if (ready_i)   state_d = IDLE;
        default:                state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o  = (state_q == IDLE);
    valid_o  = (state_q == DONE);
    result_o = valid_o ? result_q : 32'h0;
    ov_o     = valid_o & ov_q;
  end

  always_comb begin
    lane_a = width8_q ? {8'h00, op_a_q[{lane_cnt_q, 3'b000} +: 8]}
                      : op_a_q[{lane_cnt_q[0], 4'b0000} +: 16];
    lane_b = width8_q ? {8'h00, op_b_q[{lane_cnt_q, 3'b000} +: 8]}
                      : op_b_q[{lane_cnt_q[0], 4'b0000} +: 16];
  end

  ibex_pext_mul_lane u_lane (
    .a_i          (lane_a),
    .b_i          (lane_b),
    .width8_i     (width8_q),
    .signed_ops_i (signed_q),
    .sat_i        (sat_q),
    .res_o        (lane_res),
    .ov_o         (lane_ov)
  );

`ifdef IBEX_PEXT_KHM_EN
  assign sat_d = accept ? sat_i : sat_q;
`else
  logic unused_sat;
  assign unused_sat = sat_i;
  assign sat_d      = 1'b0;
`endif

  // Kill discards everything; otherwise each BUSY cycle deposits one lane.
  always_comb begin
    lane_cnt_d = lane_cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    result_d   = result_q;
    width8_d   = width8_q;
    signed_d   = signed_q;
    ov_d       = ov_q;
    if (kill_i) begin
      lane_cnt_d = 2'd0;
      result_d   = 32'h0;
      ov_d       = 1'b0;
    end else if (accept) begin
      lane_cnt_d = 2'd0;
      op_a_d     = operand_a_i;
      op_b_d     = operand_b_i;
      result_d   = 32'h0;
      width8_d   = width8_i;
      signed_d   = signed_ops_i;
      ov_d       = 1'b0;
    end else if (state_q == BUSY) begin
      if (width8_q) begin
        result_d[{lane_cnt_q, 3'b000} +: 8] = lane_res[7:0];
      end else begin
        result_d[{lane_cnt_q[0], 4'b0000} +: 16] = lane_res;
      end
      ov_d       = ov_q | lane_ov;
      lane_cnt_d = last_lane ? 2'd0 : lane_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_cnt_q <= 2'd0;
      op_a_q     <= 32'h0;
      op_b_q     <= 32'h0;
      result_q   <= 32'h0;
      width8_q   <= 1'b0;
      signed_q   <= 1'b0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      result_q   <= result_d;
      width8_q   <= width8_d;
      signed_q   <= signed_d;
    end
  end

`ifdef IBEX_PEXT_KHM_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_q <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      sat_q <= sat_d;
      ov_q  <= ov_d;
    end
  end
`else
  logic unused_ov;
  assign sat_q     = sat_d;
  assign ov_q      = 1'b0;
  assign unused_ov = ^{ov_d, lane_ov};
`endif

endmodule

// File: tb/tb_ibex_pext_simd_mul.sv
// Directed self-checking bench for ibex_pext_simd_mul; expected KHM values
// follow whether IBEX_PEXT_KHM_EN is defined for the build.
module tb_ibex_pext_simd_mul;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic        kill_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        width8_i;
  logic        signed_ops_i;
  logic        sat_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        ov_o;

  int tests_run = 0;
  int tests_failed = 0;

  ibex_pext_simd_mul dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .kill_i       (kill_i),
    .operand_a_i  (operand_a_i),
    .operand_b_i  (operand_b_i),
    .width8_i     (width8_i),
    .signed_ops_i (signed_ops_i),
    .sat_i        (sat_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .result_o     (result_o),
    .ov_o         (ov_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one op at a negedge; lat counts rising edges from the accept edge
  // until valid_o is seen (accept edge = 1), capped so a dead DUT cannot hang.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic w8, input logic sgn, input logic sat,
                               output int lat);
    @(negedge clk_i);
    operand_a_i  = a;
    operand_b_i  = b;
    width8_i     = w8;
    signed_ops_i = sgn;
    sat_i        = sat;
    valid_i      = 1'b1;
    @(posedge clk_i);
    lat = 1;
    #1 valid_i = 1'b0;
    @(negedge clk_i);
    while (valid_o !== 1'b1 && lat < 20) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
    end
  endtask

  initial begin
    int  lat;
    bit  saw_valid;

    rst_i        = 1'b1;
    valid_i      = 1'b0;
    kill_i       = 1'b0;
    ready_i      = 1'b1;
    operand_a_i  = 32'h0;
    operand_b_i  = 32'h0;
    width8_i     = 1'b0;
    signed_ops_i = 1'b0;
    sat_i        = 1'b0;

    #2;
    checkOutput("reset_ready", {31'b0, ready_o}, 32'd1);
    checkOutput("reset_valid", {31'b0, valid_o}, 32'd0);
    checkOutput("reset_result", result_o, 32'h0);
    checkOutput("reset_ov", {31'b0, ov_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // 16-bit signed: -2*5 and 3*4
    applyStimulus(32'hFFFE_0003, 32'h0005_0004, 1'b0, 1'b1, 1'b0, lat);
    checkOutput("s16_latency", lat, 32'd3);
    checkOutput("s16_result", result_o, 32'hFFF6_000C);
    checkOutput("s16_ov", {31'b0, ov_o}, 32'd0);
    checkOutput("s16_ready_in_done", {31'b0, ready_o}, 32'd0);
    @(negedge clk_i);
    checkOutput("s16_back_idle", {31'b0, ready_o}, 32'd1);
    checkOutput("s16_result_gated", result_o, 32'h0);

    // KHM16: min*min saturates, 0.5*0.5 = 0.25
    applyStimulus(32'h8000_4000, 32'h8000_4000, 1'b0, 1'b1, 1'b1, lat);
    checkOutput("khm16_latency", lat, 32'd3);
`ifdef IBEX_PEXT_KHM_EN
    checkOutput("khm16_result", result_o, 32'h7FFF_2000);
    checkOutput("khm16_ov", {31'b0, ov_o}, 32'd1);
`else
    checkOutput("khm16_result", result_o, 32'h0000_0000);
    checkOutput("khm16_ov", {31'b0, ov_o}, 32'd0);
`endif
    @(negedge clk_i);
    checkOutput("khm16_ov_gated", {31'b0, ov_o}, 32'd0);

    // KHM8 mixed lanes
    applyStimulus(32'h8080_40C0, 32'h7F80_4040, 1'b1, 1'b0, 1'b1, lat);
    checkOutput("khm8_latency", lat, 32'd5);
`ifdef IBEX_PEXT_KHM_EN
    checkOutput("khm8_result", result_o, 32'h817F_20E0);
    checkOutput("khm8_ov", {31'b0, ov_o}, 32'd1);
`else
    checkOutput("khm8_result", result_o, 32'h8000_0000);
    checkOutput("khm8_ov", {31'b0, ov_o}, 32'd0);
`endif
    @(negedge clk_i);

    // 8-bit unsigned; also confirms ov does not carry over from the previous op
    applyStimulus(32'hFF02_0304, 32'h0203_0405, 1'b1, 1'b0, 1'b0, lat);
    checkOutput("u8_latency", lat, 32'd5);
    checkOutput("u8_result", result_o, 32'hFE06_0C14);
    checkOutput("u8_ov_cleared", {31'b0, ov_o}, 32'd0);
    @(negedge clk_i);

    // 8-bit signed
    applyStimulus(32'hFF80_7F02, 32'h0280_7F03, 1'b1, 1'b1, 1'b0, lat);
    checkOutput("s8_result", result_o, 32'hFE00_0106);
    @(negedge clk_i);

    // Backpressure: hold DONE for 4 cycles while a new request is offered
    ready_i = 1'b0;
    applyStimulus(32'hFFFE_0003, 32'h0005_0004, 1'b0, 1'b1, 1'b0, lat);
    checkOutput("bp_latency", lat, 32'd3);
    for (int i = 0; i < 4; i++) begin
      operand_a_i = 32'h1111_1111;
      operand_b_i = 32'h2222_2222;
      valid_i     = 1'b1;
      checkOutput($sformatf("bp_valid_%0d", i), {31'b0, valid_o}, 32'd1);
      checkOutput($sformatf("bp_result_%0d", i), result_o, 32'hFFF6_000C);
      checkOutput($sformatf("bp_ready_%0d", i), {31'b0, ready_o}, 32'd0);
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("bp_release_valid", {31'b0, valid_o}, 32'd0);
    checkOutput("bp_release_ready", {31'b0, ready_o}, 32'd1);

    // Kill in the second BUSY cycle of an 8-bit op
    operand_a_i  = 32'hFF02_0304;
    operand_b_i  = 32'h0203_0405;
    width8_i     = 1'b1;
    signed_ops_i = 1'b0;
    sat_i        = 1'b0;
    valid_i      = 1'b1;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("kill_busy_ready", {31'b0, ready_o}, 32'd0);
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    checkOutput("kill_idle_ready", {31'b0, ready_o}, 32'd1);
    checkOutput("kill_idle_valid", {31'b0, valid_o}, 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) saw_valid = 1'b1;
    end
    checkOutput("kill_no_valid", {31'b0, saw_valid}, 32'd0);
    applyStimulus(32'hFF02_0304, 32'h0203_0405, 1'b1, 1'b0, 1'b0, lat);
    checkOutput("after_kill_latency", lat, 32'd5);
    checkOutput("after_kill_result", result_o, 32'hFE06_0C14);
    @(negedge clk_i);

    // Kill together with valid in IDLE must not accept
    valid_i = 1'b1;
    kill_i  = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    kill_i  = 1'b0;
    checkOutput("kill_idle_no_accept", {31'b0, ready_o}, 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) saw_valid = 1'b1;
    end
    checkOutput("kill_idle_no_valid", {31'b0, saw_valid}, 32'd0);

    // Asynchronous reset in the middle of BUSY
    operand_a_i  = 32'hFFFE_0003;
    operand_b_i  = 32'h0005_0004;
    width8_i     = 1'b1;
    valid_i      = 1'b1;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    checkOutput("midrst_ready", {31'b0, ready_o}, 32'd1);
    checkOutput("midrst_valid", {31'b0, valid_o}, 32'd0);
    checkOutput("midrst_result", result_o, 32'h0);
    checkOutput("midrst_ov", {31'b0, ov_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("midrst_release_ready", {31'b0, ready_o}, 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) saw_valid = 1'b1;
    end
    checkOutput("midrst_no_valid", {31'b0, saw_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
